// File: rtl/imem_load_ctrl.sv
// Instruction-memory port owner: forwards CPU fetches in RUN, or packs a byte stream into words and
// writes them from word 0. Optional load checksum is enabled by defining IMEM_LOAD_CKSUM_EN.
module imem_load_ctrl #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = 5,
  parameter logic [31:0] NOP   = 32'h00000013
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_req,
  input  logic [AW:0]   load_words,
  input  logic          byte_valid,
  input  logic [7:0]    byte_data,
  output logic          byte_ready,
  input  logic [31:0]   cpu_addr,
  output logic [31:0]   cpu_instr,
  output logic          cpu_stall,
  output logic [31:0]   mem_address,
  output logic [31:0]   mem_data_in,
  output logic          mem_rw,
  input  logic [31:0]   mem_data_out,
  output logic          load_busy,
  output logic          load_done,
  output logic [31:0]   load_cksum
);

  typedef enum logic [1:0] {StIdle, StCollect, StWrite, StDone} state_e;

  localparam logic [AW:0] DepthW = (AW+1)'(DEPTH);
  localparam logic [AW:0] OneW   = (AW+1)'(1);

  state_e        state_q, state_d;
  logic [AW-1:0] last_idx_q, last_idx_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic [31:0]   asm_q, asm_d;
  logic [AW:0]   len_clamp;
  logic          start_load;
  logic          wr_en;

  // Byte offset within the fetch PC is irrelevant for word-aligned instructions.
  logic unused_addr;
  assign unused_addr = ^cpu_addr[1:0];

  assign len_clamp  = (load_words > DepthW) ? DepthW : load_words;
  assign start_load = (state_q == StIdle) && load_req && (load_words != '0);

  always_comb begin
    state_d     = state_q;
    last_idx_d  = last_idx_q;
    idx_d       = idx_q;
    byte_cnt_d  = byte_cnt_q;
    asm_d       = asm_q;
    wr_en       = 1'b0;
    byte_ready  = 1'b0;
    cpu_stall   = 1'b1;
    load_busy   = 1'b1;
    load_done   = 1'b0;
    cpu_instr   = NOP;
    mem_rw      = 1'b1;
    mem_address = {{(32-AW){1'b0}}, idx_q};
    mem_data_in = asm_q;

    unique case (state_q)
      StIdle: begin
        cpu_stall   = 1'b0;
        load_busy   = 1'b0;
        cpu_instr   = mem_data_out;
        mem_address = {2'b00, cpu_addr[31:2]};
        if (load_req) begin
          if (load_words == '0) begin
            state_d = StDone;
          end else begin
            state_d    = StCollect;
            last_idx_d = AW'(len_clamp - OneW);
            idx_d      = '0;
            byte_cnt_d = '0;
          end
        end
      end
      StCollect: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          asm_d[{byte_cnt_q, 3'b000} +: 8] = byte_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) state_d = StWrite;
        end
      end
      StWrite: begin
        wr_en  = 1'b1;
        mem_rw = 1'b0;
        if (idx_q == last_idx_q) begin
          state_d = StDone;
        end else begin
          idx_d      = idx_q + AW'(1);
          byte_cnt_d = '0;
          state_d    = StCollect;
        end
      end
      StDone: begin
        load_done = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      last_idx_q <= '0;
      idx_q      <= '0;
      byte_cnt_q <= '0;
      asm_q      <= '0;
    end else begin
      state_q    <= state_d;
      last_idx_q <= last_idx_d;
      idx_q      <= idx_d;
      byte_cnt_q <= byte_cnt_d;
      asm_q      <= asm_d;
    end
  end

`ifdef IMEM_LOAD_CKSUM_EN
  logic [31:0] cksum_q, cksum_d;

  always_comb begin
    cksum_d = cksum_q;
    if (start_load) cksum_d = '0;
    else if (wr_en) cksum_d = cksum_q + asm_q;
  end

  always_ff @(posedge clk) begin
    if (reset) cksum_q <= '0;
    else       cksum_q <= cksum_d;
  end

  assign load_cksum = cksum_q;
`else
  logic unused_cksum;
  assign unused_cksum = start_load ^ wr_en;
  assign load_cksum   = 32'h0;
`endif

endmodule
